// File: rtl/mesm6_iobus_pkg.sv
// Shared types for the MESM-6 data-bus fabric: transaction FSM states and
// the helper that extracts the slot number from the upper address bits.
package mesm6_iobus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ERR,
        RESP
    } state_t;

    function automatic int unsigned slot_index(input logic [31:0] addr,
                                               input int aw,
                                               input int sb);
        return (addr >> (aw - sb)) & ((32'd1 << sb) - 32'd1);
    endfunction

endpackage

// File: rtl/mesm6_iobus_wdog.sv
// Access watchdog for mesm6_iobus; present only when MESM6_IOBUS_TIMEOUT_EN
// is defined. Counts cycles spent waiting on a slot and flags expiry.
`ifdef MESM6_IOBUS_TIMEOUT_EN
module mesm6_iobus_wdog #(
    parameter int TO_CYCLES = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [15:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 16'd1;
        end
    end

    // Fires in the last waiting cycle so the FSM leaves after TO_CYCLES cycles.
    assign expire = en && (count == 16'(TO_CYCLES - 1));

endmodule
`endif

// File: rtl/mesm6_iobus.sv
// Registered data-bus fabric between the MESM-6 core and NSLOT peripheral slots.
// Define MESM6_IOBUS_TIMEOUT_EN to add the access watchdog and timeout error path.
module mesm6_iobus
    import mesm6_iobus_pkg::*;
#(
    parameter int               NSLOT     = 8,
    parameter int               AW        = 15,
    parameter int               DW        = 48,
    parameter int               SB        = $clog2(NSLOT),
    parameter logic [NSLOT-1:0] SLOT_EN   = {NSLOT{1'b1}},
    parameter int               TO_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [AW-1:0]       m_addr,
    input  logic                m_rd,
    input  logic                m_wr,
    input  logic [DW-1:0]       m_wdata,
    output logic [DW-1:0]       m_rdata,
    output logic                m_done,
    output logic [AW-1:0]       s_addr,
    output logic [DW-1:0]       s_wdata,
    output logic [NSLOT-1:0]    s_rd,
    output logic [NSLOT-1:0]    s_wr,
    input  logic [NSLOT*DW-1:0] s_rdata,
    input  logic [NSLOT-1:0]    s_done,
    input  logic [NSLOT-1:0]    s_irq,
    input  logic [NSLOT-1:0]    irq_mask,
    output logic [NSLOT-1:0]    irq_vec,
    output logic                berr,
    output logic [AW-1:0]       berr_addr,
    input  logic                berr_clr
);

    state_t           state;
    state_t           next_state;
    logic             req;
    logic [SB-1:0]    req_slot;
    logic             req_populated;
    logic [SB-1:0]    slot_q;
    logic             is_wr;
    logic [NSLOT-1:0] slot_bit;
    logic             slot_done;
    logic [DW-1:0]    slot_word;
    logic             expire;

    assign req           = m_rd | m_wr;
    assign req_slot      = SB'(slot_index(32'(m_addr), AW, SB));
    // Slot numbers beyond NSLOT (non power-of-two NSLOT) count as unpopulated.
    assign req_populated = (int'(req_slot) < NSLOT) && SLOT_EN[req_slot];
    assign slot_bit      = {{(NSLOT-1){1'b0}}, 1'b1} << slot_q;
    assign slot_done     = s_done[slot_q];
    assign slot_word     = s_rdata[slot_q*DW +: DW];

`ifdef MESM6_IOBUS_TIMEOUT_EN
    mesm6_iobus_wdog #(
        .TO_CYCLES (TO_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != ACCESS),
        .en      (state == ACCESS),
        .expire  (expire)
    );
`else
    // Without the watchdog TO_CYCLES has no effect.
    logic unused_to_cycles;
    assign unused_to_cycles = (TO_CYCLES > 0);
    assign expire           = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = req_populated ? ACCESS : ERR;
            ACCESS:  if (slot_done) next_state = RESP;
                     else if (expire) next_state = ERR;
            ERR:     next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        s_rd   = '0;
        s_wr   = '0;
        m_done = 1'b0;
        case (state)
            ACCESS: begin
                if (is_wr) s_wr = slot_bit;
                else       s_rd = slot_bit;
            end
            RESP:    m_done = 1'b1;
            default: ;
        endcase
    end

    // Request latch and read-data capture; write wins when both are requested.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_addr  <= '0;
            s_wdata <= '0;
            slot_q  <= '0;
            is_wr   <= 1'b0;
            m_rdata <= '0;
        end else begin
            if (state == IDLE && req) begin
                s_addr  <= m_addr;
                s_wdata <= m_wdata;
                slot_q  <= req_slot;
                is_wr   <= m_wr;
            end
            if (state == ACCESS && slot_done) begin
                m_rdata <= is_wr ? '0 : slot_word;
            end else if (state == ERR) begin
                m_rdata <= '0;
            end
        end
    end

    // Only the first error is recorded; a clear beats a same-cycle error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            berr      <= 1'b0;
            berr_addr <= '0;
        end else if (berr_clr) begin
            berr      <= 1'b0;
            berr_addr <= '0;
        end else if (state == ERR && !berr) begin
            berr      <= 1'b1;
            berr_addr <= s_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_vec <= '0;
        end else begin
            irq_vec <= s_irq & irq_mask;
        end
    end

endmodule

// File: doc/mesm6_iobus.md
Name: mesm6_iobus

Overview:
Parametrised registered data-bus fabric between the MESM-6 core data port and up to NSLOT peripheral slots (RAM, PIC, GPIO, timer, UART, VGA, ...).
- Decodes slot from upper address bits and runs one transaction at a time through a small FSM.
- Adds timeout, bus-error reporting and a masked, registered interrupt vector.
- Replaces fixed per-peripheral wiring with one generic block instantiated at board top level.

Parameters:
NSLOT, 8, number of peripheral slots (2..16)
AW, 15, address width
DW, 48, data width
SB, $clog2(NSLOT), slot-select bits, taken from m_addr[AW-1 -: SB]
SLOT_EN, {NSLOT{1'b1}}, per-slot populated mask; an unpopulated slot answers with a bus error
TO_CYCLES, 255, cycles to wait for s_done before the timeout fires (1..65535)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
m_addr  in  AW  master address
m_rd  in  1  master read request, held until m_done
m_wr  in  1  master write request, held until m_done
m_wdata  in  DW  master write data
m_rdata  out  DW  read data, valid while m_done=1
m_done  out  1  one-cycle completion pulse
s_addr  out  AW  latched address, shared by all slots
s_wdata  out  DW  latched write data, shared by all slots
s_rd  out  NSLOT  one-hot slot read strobe
s_wr  out  NSLOT  one-hot slot write strobe
s_rdata  in  NSLOT*DW  slot read data, packed, slot i at [i*DW +: DW]
s_done  in  NSLOT  slot completion
s_irq  in  NSLOT  slot interrupt requests (level)
irq_mask  in  NSLOT  interrupt enable per slot
irq_vec  out  NSLOT  registered s_irq & irq_mask
berr  out  1  sticky bus-error flag
berr_addr  out  AW  address of the first erroring access
berr_clr  in  1  clears berr and berr_addr

Behaviour:
- Reset (async, reset_n=0): state IDLE. All of the following are 0: m_done, m_rdata, s_rd, s_wr, s_addr, s_wdata, irq_vec, berr, berr_addr. Watchdog counter cleared. Any in-flight access is abandoned with no m_done.
- IDLE: when m_rd|m_wr:
  - latch m_addr, m_wdata, slot index and direction (m_wr=1 wins if both are set);
  - next state ACCESS if SLOT_EN[slot], otherwise ERR.
- ACCESS: s_rd[slot] or s_wr[slot] held high and the counter increments.
  - s_done[slot]=1: capture s_rdata slot word (0 for writes), drop the strobe, go to RESP.
  - Counter reaches TO_CYCLES first: go to ERR.
- ERR: strobes low; m_rdata=0. If berr=0, set berr and berr_addr=latched address; a later error does not overwrite them. Go to RESP.
- RESP: m_done=1 for exactly one cycle, then IDLE.
  - The master must drop m_rd/m_wr in the cycle it samples m_done.
  - IDLE re-samples requests one cycle after RESP.
- Latency, populated slot: request in cycle 0, strobe from cycle 1, s_done in cycle k gives m_done in cycle k+1. Fastest response is m_done in cycle 2. Error path on an unpopulated slot: m_done in cycle 2.
- s_done from a slot other than the latched one, or while IDLE, is ignored.
- berr_clr wins over a simultaneous error set in the same cycle.
- irq_vec updates every cycle, one-cycle registered; it is independent of the transaction FSM.
- m_rdata holds its value until the next RESP.

Optional Feature:
MESM6_IOBUS_TIMEOUT_EN
- Defined: watchdog and timeout-to-ERR path present, as described above.
- Undefined: no counter logic; ACCESS waits for s_done indefinitely. berr is raised only by unpopulated-slot accesses. TO_CYCLES is ignored.

Decomposition:
- Package mesm6_iobus_pkg: FSM state enum (IDLE, ACCESS, ERR, RESP) and a slot-index helper function.
- Sub-module mesm6_iobus_wdog: timeout counter with clear/enable inputs and an expire output; compiled only under MESM6_IOBUS_TIMEOUT_EN.

Test Plan:
- Read slot 2 at 0x2345, slot answers s_done after 3 cycles with 48'h123456789ABC -> s_rd=8'b00000100, m_done pulse, m_rdata=48'h123456789ABC, berr=0.
- Write 48'hFFFF to slot 5 at 0x5010, immediate s_done -> s_wr[5] high 1 cycle, s_wdata=48'hFFFF, s_addr=0x5010, m_done in cycle 2.
- SLOT_EN=8'h7F, read at 0x7000 -> no strobe, m_done in cycle 2, m_rdata=0, berr=1, berr_addr=0x7000; berr_clr -> berr=0.
- Macro defined, TO_CYCLES=10, slot 1 never responds -> m_done in cycle 12, berr=1; a second timeout leaves berr_addr unchanged.
- reset_n pulsed low during ACCESS -> strobes drop immediately, no m_done, state IDLE; the next read completes normally.
- s_irq=8'hF0, irq_mask=8'h30 -> irq_vec=8'h30 one cycle later.
